// File: rtl/apb_tx_dp.sv
// apb_tx_dp: UART transmit datapath.
// Holds the current bit index for the upstream control stage. Generates the
// per-bit baud strobe from a latched divisor, shifts the latched payload onto
// txd, and reports frame progress (busy/done).
module apb_tx_dp #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [9:0]       tx_data,
   input  logic [DIV_W-1:0] divisor,
   input  logic             tx_en,
   input  logic             start_bit,
   input  logic             end_bit,
   input  logic [9:0]       data_bit,
   input  logic [9:0]       bit_cntn,
   output logic [9:0]       bit_cnto,
   output logic             baud_clk,
   output logic             txd,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t           r_state;
   logic [9:0]       r_bit_cnt;
   logic [9:0]       r_payload;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_baud_cnt;
   logic             r_txd;
   logic             r_done;

   logic [DIV_W-1:0] w_div_last;
   logic             w_baud;
   logic             w_txd_nxt;

   // Terminal count is div_eff-1; divisors 0 and 1 both give 0, so the
   // strobe fires every SEND cycle.
   assign w_div_last = (r_div == '0) ? '0 : (r_div - DIV_W'(1));

   // The strobe depends only on registered state, so input changes cannot
   // glitch it.
   assign w_baud = (r_state == S_SEND) && (r_baud_cnt == w_div_last);

   // Next serial line value, in priority order: idle/abort high, start low,
   // stop high, then the selected payload bit. Out-of-range indices idle high.
   always_comb begin
      // NOTE: assign the default first so every path writes the signal; a
      // missing branch would otherwise infer a latch.
      w_txd_nxt = 1'b1;
      if ((r_state == S_SEND) && tx_en) begin
         if (start_bit) begin
            w_txd_nxt = 1'b0;
         end else if (end_bit) begin
            w_txd_nxt = 1'b1;
         end else if (data_bit <= 10'd9) begin
            w_txd_nxt = r_payload[data_bit[3:0]];
         end
      end
   end

   // Register the next bit index from control so control sees it as current.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the values from before the edge.
      if (!rstn) begin
         r_bit_cnt <= '0;
      end else begin
         r_bit_cnt <= bit_cntn;
      end
   end

   // Baud counter: runs only in SEND, wraps at div_eff-1, and is held at zero
   // otherwise. This makes every frame start on a full bit period.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_baud_cnt <= '0;
      end else if (r_state != S_SEND) begin
         r_baud_cnt <= '0;
      end else if (w_baud) begin
         r_baud_cnt <= '0;
      end else begin
         r_baud_cnt <= r_baud_cnt + DIV_W'(1);
      end
   end

   // Frame FSM with registered txd/done. The shadow payload and divisor are
   // captured when the frame starts, so register writes mid-frame are ignored.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_txd     <= 1'b1;
         r_done    <= 1'b0;
         // NOTE: the shadow registers are reset with the control state even
         // though they are reloaded before use. This keeps the datapath free
         // of X after reset.
         r_payload <= '0;
         r_div     <= '0;
      end else begin
         r_txd  <= w_txd_nxt;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (tx_en) begin
                  r_payload <= tx_data;
                  r_div     <= divisor;
                  r_state   <= S_SEND;
               end
            end
            S_SEND: begin
               // Dropping tx_en aborts the frame, even on the final strobe.
               if (!tx_en) begin
                  r_state <= S_IDLE;
               end else if (end_bit && w_baud) begin
                  r_done  <= 1'b1;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (!tx_en) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bit_cnto = r_bit_cnt;
   assign baud_clk = w_baud;
   assign txd      = r_txd;
   assign busy     = (r_state == S_SEND);
   assign done     = r_done;

endmodule

// File: tb/tb_apb_tx_dp.sv
// tb_apb_tx_dp: directed bench for apb_tx_dp.
// The bench includes a small model of the upstream control stage. It applies a
// table of frames with hand-computed line patterns, then runs hand-written
// sequences for abort, simultaneous abort, and mid-frame reset.
module tb_apb_tx_dp;

   logic        clk;
   logic        rstn;
   logic [9:0]  tx_data;
   logic [15:0] divisor;
   logic        tx_en;
   logic        mode;
   logic        start_bit;
   logic        end_bit;
   logic [9:0]  data_bit;
   logic [9:0]  bit_cntn;
   logic [9:0]  bit_cnto;
   logic        baud_clk;
   logic        txd;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;

   apb_tx_dp #(.DIV_W(16)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .tx_data   (tx_data),
      .divisor   (divisor),
      .tx_en     (tx_en),
      .start_bit (start_bit),
      .end_bit   (end_bit),
      .data_bit  (data_bit),
      .bit_cntn  (bit_cntn),
      .bit_cnto  (bit_cnto),
      .baud_clk  (baud_clk),
      .txd       (txd),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream control stage model: start at index 0, data bits 1..8 (or 1..10),
   // stop at 9 (or 11), advance on baud_clk, hold at stop, clear when disabled.
   logic [9:0] stop_idx;
   assign stop_idx  = mode ? 10'd11 : 10'd9;
   assign start_bit = (bit_cnto == 10'd0);
   assign end_bit   = (bit_cnto == stop_idx);
   assign data_bit  = ((bit_cnto != 10'd0) && (bit_cnto < stop_idx)) ? (bit_cnto - 10'd1) : 10'h3FF;
   assign bit_cntn  = !tx_en ? 10'd0 :
                      (baud_clk && (bit_cnto < stop_idx)) ? (bit_cnto + 10'd1) : bit_cnto;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // line[i] is the expected txd level for bit i (start, data..., stop).
   typedef struct {
      logic [15:0] div;
      logic        mode;
      logic [9:0]  data;
      logic [11:0] line;
      int          de;
      int          hold;
      logic        chg;
   } vec_t;

   vec_t vecs[5];

   // Run one frame from IDLE: check every cycle, hold, then rearm.
   // Expected values after edge n (edge 1 enters SEND):
   //    txd = 1 at n=1, then line[(n-2)/de]
   //    busy for n < total, done at n == total
   //    bit_cnto = min((n-1)/de, stop)
   task automatic run_frame(input vec_t v, input int idx);
      int nb;
      int total;
      int exp_cnt;
      logic exp_txd;
      nb    = v.mode ? 12 : 10;
      total = nb * v.de + 1;
      tx_data = v.data;
      divisor = v.div;
      mode    = v.mode;
      tx_en   = 1'b1;
      for (int n = 1; n <= total; n++) begin
         @(negedge clk);
         if (n == 1) exp_txd = 1'b1;
         else        exp_txd = v.line[(n - 2) / v.de];
         exp_cnt = (n - 1) / v.de;
         if (exp_cnt > nb - 1) exp_cnt = nb - 1;
         check($sformatf("f%0d_txd_n%0d", idx, n), txd, exp_txd);
         check($sformatf("f%0d_busy_n%0d", idx, n), busy, (n < total));
         check($sformatf("f%0d_done_n%0d", idx, n), done, (n == total));
         check($sformatf("f%0d_baud_n%0d", idx, n), baud_clk, (n < total) && ((n % v.de) == 0));
         check($sformatf("f%0d_cnt_n%0d", idx, n), bit_cnto, exp_cnt);
         if (v.chg && (n == total / 2)) begin
            tx_data = 10'h000;
            divisor = 16'd7;
         end
      end
      for (int h = 1; h <= v.hold; h++) begin
         @(negedge clk);
         check($sformatf("f%0d_hold_txd_%0d", idx, h), txd, 1'b1);
         check($sformatf("f%0d_hold_busy_%0d", idx, h), busy, 1'b0);
         check($sformatf("f%0d_hold_done_%0d", idx, h), done, 1'b0);
         check($sformatf("f%0d_hold_baud_%0d", idx, h), baud_clk, 1'b0);
         check($sformatf("f%0d_hold_cnt_%0d", idx, h), bit_cnto, nb - 1);
      end
      tx_en = 1'b0;
      @(negedge clk);
      check($sformatf("f%0d_rearm_cnt", idx), bit_cnto, 10'd0);
      check($sformatf("f%0d_rearm_busy", idx), busy, 1'b0);
   endtask

   initial begin
      //           div    mode  data     line     de hold chg
      vecs[0] = '{16'd4, 1'b0, 10'h0A5, 12'h34A, 4, 3,  1'b0};
      vecs[1] = '{16'd1, 1'b1, 10'h3FF, 12'hFFE, 1, 3,  1'b0};
      vecs[2] = '{16'd0, 1'b0, 10'h03C, 12'h278, 1, 20, 1'b1};
      vecs[3] = '{16'd3, 1'b1, 10'h2C3, 12'hD86, 3, 3,  1'b1};
      vecs[4] = '{16'd2, 1'b0, 10'h155, 12'h2AA, 2, 3,  1'b0};

      // Reset held for three cycles while tx_en is asserted.
      rstn    = 1'b0;
      tx_en   = 1'b1;
      mode    = 1'b0;
      tx_data = 10'h0A5;
      divisor = 16'd4;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("rst_txd_%0d", i), txd, 1'b1);
         check($sformatf("rst_cnt_%0d", i), bit_cnto, 10'd0);
         check($sformatf("rst_busy_%0d", i), busy, 1'b0);
         check($sformatf("rst_done_%0d", i), done, 1'b0);
         check($sformatf("rst_baud_%0d", i), baud_clk, 1'b0);
      end
      tx_en = 1'b0;
      rstn  = 1'b1;
      @(negedge clk);

      // Table of frames.
      for (int i = 0; i < 5; i++) begin
         run_frame(vecs[i], i);
      end

      // Abort during data bit 3 (index 4), divisor 3.
      tx_data = 10'h0A5;
      divisor = 16'd3;
      mode    = 1'b0;
      tx_en   = 1'b1;
      for (int n = 1; n <= 13; n++) @(negedge clk);
      check("abort_cnt_before", bit_cnto, 10'd4);
      check("abort_busy_before", busy, 1'b1);
      tx_en = 1'b0;
      @(negedge clk);
      check("abort_txd", txd, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_cnt", bit_cnto, 10'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("abort_nodone_%0d", i), done, 1'b0);
         check($sformatf("abort_idle_txd_%0d", i), txd, 1'b1);
      end
      run_frame(vecs[0], 10);

      // tx_en falls in the same cycle as the final baud_clk: abort, no done.
      tx_data = 10'h0A5;
      divisor = 16'd2;
      mode    = 1'b0;
      tx_en   = 1'b1;
      for (int n = 1; n <= 20; n++) @(negedge clk);
      check("simul_final_baud", baud_clk, 1'b1);
      check("simul_stop_idx", bit_cnto, 10'd9);
      tx_en = 1'b0;
      @(negedge clk);
      check("simul_done", done, 1'b0);
      check("simul_busy", busy, 1'b0);
      check("simul_txd", txd, 1'b1);
      check("simul_cnt", bit_cnto, 10'd0);
      @(negedge clk);
      check("simul_done_late", done, 1'b0);

      // Reset asserted mid-frame.
      tx_data = 10'h0A5;
      divisor = 16'd4;
      mode    = 1'b0;
      tx_en   = 1'b1;
      for (int n = 1; n <= 10; n++) @(negedge clk);
      check("mrst_busy_before", busy, 1'b1);
      rstn = 1'b0;
      @(negedge clk);
      check("mrst_txd", txd, 1'b1);
      check("mrst_cnt", bit_cnto, 10'd0);
      check("mrst_busy", busy, 1'b0);
      check("mrst_done", done, 1'b0);
      check("mrst_baud", baud_clk, 1'b0);
      rstn  = 1'b1;
      tx_en = 1'b0;
      @(negedge clk);
      run_frame(vecs[4], 11);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
